q_out_pack8: RTL and testbench
==============================

# q_out_pack8

Downstream stage of the 8-bit quantized multiply datapath: consumes the per-cycle 8-bit result stream (enable + byte + 16-bit range MIN/MAX) and packs 4 bytes per 32-bit word. Packed words are buffered in a small word FIFO and written out over a valid/ready write port. The block also tracks frame-level byte min/max and latches the final range, so the controller can read back statistics for the next layer's quantization parameters.

## Interface
- DEPTH, 4: word FIFO entries (power of 2, ≥2)
- LEN_W, 16: width of frame byte count
- CLK  in  1  clock, all logic on rising edge
- RESET_X  in  1  reset, synchronous, active-high (1 = reset)
- START  in  1  one-cycle pulse; begins a frame, samples LEN
- LEN  in  LEN_W  bytes in frame (0 allowed)
- INPUT_EN  in  1  C_IN/MIN_IN/MAX_IN valid this cycle
- C_IN  in  8  result byte (unsigned quantized)
- MIN_IN, MAX_IN  in  16 each  range of the producing stage
- IN_READY  out  1  advisory: state RUN and FIFO free entries ≥ 2
- WR_VALID  out  1  WR_DATA/WR_LAST valid
- WR_DATA  out  32  packed word, byte k in bits [8k+7:8k]
- WR_LAST  out  1  final word of frame
- WR_READY  in  1  sink accepts word
- BUSY  out  1  state ≠ IDLE
- DONE  out  1  one-cycle pulse at frame end
- OVF  out  1  sticky overflow, cleared by START
- C_MIN, C_MAX  out  8 each  min/max byte seen in frame
- RANGE_MIN, RANGE_MAX  out  16 each  MIN_IN/MAX_IN sampled with last byte

## Operation
- States: IDLE, RUN, FLUSH, DRAIN, FIN.
- IDLE: INPUT_EN ignored. START with LEN=0 → FIN (no words written). START with LEN>0 → RUN; remaining=LEN, lane=0, OVF=0, C_MIN=FF, C_MAX=00.
- START outside IDLE ignored.
- RUN: each INPUT_EN byte goes to lane `lane`, lane increments mod 4, remaining decrements; C_MIN/C_MAX updated same edge.
- Byte completing lane 3 → word pushed to FIFO. If FIFO full at push → word dropped, OVF=1, counting continues.
- Last byte (remaining=1): RANGE_MIN/MAX latched.
  - If it completes lane 3 → word pushed with LAST=1, → DRAIN.
  - Else → FLUSH.
- FLUSH: one cycle; pushes partial word, unused upper lanes zero, LAST=1 (full FIFO → drop + OVF). → DRAIN.
- DRAIN: INPUT_EN ignored; wait until FIFO empty and no transfer pending → FIN.
- FIN: DONE=1 one cycle → IDLE.
- Write handshake: word transfers on WR_VALID & WR_READY. WR_DATA/WR_LAST stable while WR_VALID & !WR_READY. FIFO is show-ahead, registered output.
- Simultaneous push and pop on a full FIFO: push succeeds, no OVF.
- RESET_X mid-frame: FIFO flushed, partial word discarded, state IDLE.

## Timing
- Reset values: IN_READY, WR_VALID, WR_LAST, BUSY, DONE, OVF = 0. WR_DATA = 0. C_MIN = FF, C_MAX = 00. RANGE_MIN/MAX = 0.
- START at cycle t → BUSY=1 and IN_READY (if space) from t+1. A byte in cycle t+1 is accepted.
- Fourth byte at cycle t → WR_VALID=1 at t+1 (if FIFO was empty).
- Partial last byte at t: FLUSH at t+1, WR_VALID at t+2.
- Last word handshake at t → FIN at t+1 (DONE high), IDLE at t+2.
- LEN=0: START at t → DONE at t+1.
- Sustained throughput: 1 byte/cycle in, 1 word per 4 cycles out with WR_READY=1.

## Structure
- Shared package q_npu_pkg: state enum for this block, BYTES_PER_WORD=4, word width 32.
- Sub-module q_word_fifo: synchronous show-ahead FIFO, DEPTH×33 bits (data + last). Ports: push/pop/full/empty/free-count.
- Top contains the FSM, lane/remaining counters, packing register, and statistics.

## Test plan
- LEN=8, bytes 01..08 back-to-back, WR_READY=1 → words 04030201, 08070605 (LAST on second); DONE once; C_MIN=01, C_MAX=08.
- LEN=5, bytes 10,20,30,40,50 → words 40302010, 00000050 with LAST; RANGE_* = MIN_IN/MAX_IN of byte 5.
- LEN=0 START → DONE one cycle after START, WR_VALID never high, BUSY high one cycle.
- LEN=24, WR_READY=0 throughout, DEPTH=4 → IN_READY drops after 3 words; 5th and 6th words dropped; OVF=1; 4 words emitted after WR_READY rises; DONE after the last of them.
- RESET_X at byte 6 of LEN=8 → all outputs at reset values next cycle. A new START with LEN=4 then yields a single clean word.
- START pulsed during RUN, and INPUT_EN pulsed in IDLE → both ignored; counters and outputs unchanged.

Source files
------------

// File: rtl/q_npu_pkg.sv
// q_npu_pkg: types and constants shared by the 8-bit quantized datapath.
// Holds the output packer state enum, the word geometry, and a small helper
// that drops a byte into one lane of a packed word.
package q_npu_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } pack_state_e;

  // Returns word with byte b written into lane (bits [8*lane+7:8*lane]).
  function automatic logic [WORD_W-1:0] set_lane(input logic [WORD_W-1:0] word,
                                                 input logic [LANE_W-1:0] lane,
                                                 input logic [7:0]        b);
    logic [WORD_W-1:0] w;
    w = word;
    w[{lane, 3'b000} +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/q_word_fifo.sv
// q_word_fifo: synchronous show-ahead FIFO.
// The head entry is visible on rd_data_o whenever empty_o is low; pop_i
// consumes it. A push on a full FIFO is accepted only when a pop happens in
// the same cycle. rd_data_o reads as zero while empty.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i/push_data_i  write request and entry
//   pop_i             consume head entry
//   rd_data_o         head entry
//   full_o, empty_o   occupancy flags
//   free_o            number of free entries
module q_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     free_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign free_o    = (AW+1)'(DEPTH) - cnt_q;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: empty gating hides stale contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/q_out_pack8.sv
// q_out_pack8: packs the 8-bit result stream into 32-bit words (byte k in
// bits [8k+7:8k]), buffers them in a word FIFO and writes them out over a
// valid/ready port. Tracks per-frame byte min/max and latches the producer
// range that came with the final byte.
// Ports:
//   CLK, RESET_X          clock, synchronous active-high reset
//   START, LEN            frame start pulse and byte count (0 allowed)
//   INPUT_EN, C_IN        byte stream
//   MIN_IN, MAX_IN        producer range, sampled with the last byte
//   IN_READY              advisory: running and >= 2 free FIFO entries
//   WR_VALID/DATA/LAST    word output, WR_READY accepts
//   BUSY, DONE, OVF       status (OVF sticky until next START)
//   C_MIN, C_MAX          frame byte min/max
//   RANGE_MIN, RANGE_MAX  latched producer range
module q_out_pack8
  import q_npu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic              CLK,
  input  logic              RESET_X,
  input  logic              START,
  input  logic [LEN_W-1:0]  LEN,
  input  logic              INPUT_EN,
  input  logic [7:0]        C_IN,
  input  logic [15:0]       MIN_IN,
  input  logic [15:0]       MAX_IN,
  output logic              IN_READY,
  output logic              WR_VALID,
  output logic [31:0]       WR_DATA,
  output logic              WR_LAST,
  input  logic              WR_READY,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVF,
  output logic [7:0]        C_MIN,
  output logic [7:0]        C_MAX,
  output logic [15:0]       RANGE_MIN,
  output logic [15:0]       RANGE_MAX
);

  localparam int CW = $clog2(DEPTH) + 1;

  pack_state_e       state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        cmin_q, cmin_d, cmax_q, cmax_d;
  logic [15:0]       rmin_q, rmin_d, rmax_q, rmax_d;

  logic              push, push_last, pop, fifo_push;
  logic [WORD_W-1:0] push_word, word_new;
  logic [WORD_W:0]   rd_data;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_free;

  assign pop      = !fifo_empty && WR_READY;
  assign word_new = set_lane(pack_q, lane_q, C_IN);

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    rem_d     = rem_q;
    pack_d    = pack_q;
    ovf_d     = ovf_q;
    cmin_d    = cmin_q;
    cmax_d    = cmax_q;
    rmin_d    = rmin_q;
    rmax_d    = rmax_q;
    push      = 1'b0;
    push_last = 1'b0;
    push_word = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          ovf_d   = 1'b0;
          cmin_d  = 8'hFF;
          cmax_d  = 8'h00;
          lane_d  = '0;
          pack_d  = '0;
          rem_d   = LEN;
          state_d = (LEN == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (INPUT_EN) begin
          pack_d = word_new;
          lane_d = lane_q + LANE_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (C_IN < cmin_q) cmin_d = C_IN;
          if (C_IN > cmax_q) cmax_d = C_IN;
          if (lane_q == LANE_W'(BYTES_PER_WORD-1)) begin
            push      = 1'b1;
            push_word = word_new;
            pack_d    = '0;   // next word starts with zeroed upper lanes
          end
          if (rem_q == LEN_W'(1)) begin
            rmin_d = MIN_IN;
            rmax_d = MAX_IN;
            if (lane_q == LANE_W'(BYTES_PER_WORD-1)) begin
              push_last = 1'b1;
              state_d   = ST_DRAIN;
            end else begin
              state_d   = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        push      = 1'b1;
        push_word = pack_q;
        push_last = 1'b1;
        pack_d    = '0;
        state_d   = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave as soon as the final handshake happens, not a cycle later.
        if (fifo_empty || (fifo_free == CW'(DEPTH-1) && pop)) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A full FIFO still takes the push if the head leaves this cycle.
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  assign fifo_push = push && (!fifo_full || pop);

  always_ff @(posedge CLK) begin
    if (RESET_X) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      rem_q   <= '0;
      pack_q  <= '0;
      ovf_q   <= 1'b0;
      cmin_q  <= 8'hFF;
      cmax_q  <= 8'h00;
      rmin_q  <= '0;
      rmax_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      rem_q   <= rem_d;
      pack_q  <= pack_d;
      ovf_q   <= ovf_d;
      cmin_q  <= cmin_d;
      cmax_q  <= cmax_d;
      rmin_q  <= rmin_d;
      rmax_q  <= rmax_d;
    end
  end

  q_word_fifo #(.DEPTH(DEPTH), .W(WORD_W+1)) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RESET_X),
    .push_i      (fifo_push),
    .push_data_i ({push_last, push_word}),
    .pop_i       (pop),
    .rd_data_o   (rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .free_o      (fifo_free)
  );

  assign WR_VALID  = !fifo_empty;
  assign WR_DATA   = rd_data[WORD_W-1:0];
  assign WR_LAST   = rd_data[WORD_W];
  assign IN_READY  = (state_q == ST_RUN) && (fifo_free >= CW'(2));
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = (state_q == ST_FIN);
  assign OVF       = ovf_q;
  assign C_MIN     = cmin_q;
  assign C_MAX     = cmax_q;
  assign RANGE_MIN = rmin_q;
  assign RANGE_MAX = rmax_q;

endmodule

// File: tb/tb_q_out_pack8.sv
// Directed bench for q_out_pack8: hand-computed words, flags and statistics.
module tb_q_out_pack8;

  logic        CLK = 1'b0;
  logic        RESET_X = 1'b1;
  logic        START = 1'b0;
  logic [15:0] LEN = '0;
  logic        INPUT_EN = 1'b0;
  logic [7:0]  C_IN = '0;
  logic [15:0] MIN_IN = '0, MAX_IN = '0;
  logic        IN_READY, WR_VALID, WR_LAST, BUSY, DONE, OVF;
  logic [31:0] WR_DATA;
  logic        WR_READY = 1'b1;
  logic [7:0]  C_MIN, C_MAX;
  logic [15:0] RANGE_MIN, RANGE_MAX;

  int n_vec = 0, n_err = 0, done_cnt = 0;
  logic [32:0] wq[$];
  bit ok;

  always #5 CLK = ~CLK;

  q_out_pack8 #(.DEPTH(4), .LEN_W(16)) dut (
    .CLK(CLK), .RESET_X(RESET_X), .START(START), .LEN(LEN),
    .INPUT_EN(INPUT_EN), .C_IN(C_IN), .MIN_IN(MIN_IN), .MAX_IN(MAX_IN),
    .IN_READY(IN_READY), .WR_VALID(WR_VALID), .WR_DATA(WR_DATA),
    .WR_LAST(WR_LAST), .WR_READY(WR_READY), .BUSY(BUSY), .DONE(DONE),
    .OVF(OVF), .C_MIN(C_MIN), .C_MAX(C_MAX),
    .RANGE_MIN(RANGE_MIN), .RANGE_MAX(RANGE_MAX)
  );

  // Sink: record every word handshake and every DONE cycle.
  always @(posedge CLK) begin
    if (!RESET_X && WR_VALID && WR_READY) wq.push_back({WR_LAST, WR_DATA});
    if (!RESET_X && DONE) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic start(input logic [15:0] l);
    START = 1'b1; LEN = l; tick(); START = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic [15:0] mn, input logic [15:0] mx);
    INPUT_EN = 1'b1; C_IN = b; MIN_IN = mn; MAX_IN = mx; tick(); INPUT_EN = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      if (DONE) seen = 1'b1; else tick();
    end
    if (DONE) seen = 1'b1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_in_ready"}, IN_READY, 0);
    chk({pfx, "_wr_valid"}, WR_VALID, 0);
    chk({pfx, "_wr_last"},  WR_LAST, 0);
    chk({pfx, "_wr_data"},  WR_DATA, 0);
    chk({pfx, "_busy"},     BUSY, 0);
    chk({pfx, "_done"},     DONE, 0);
    chk({pfx, "_ovf"},      OVF, 0);
    chk({pfx, "_cmin"},     C_MIN, 8'hFF);
    chk({pfx, "_cmax"},     C_MAX, 8'h00);
    chk({pfx, "_range"},    {RANGE_MIN, RANGE_MAX}, 0);
  endtask

  task automatic chk_word(input string tag, input logic [32:0] exp);
    if (wq.size() == 0) chk({tag, "_missing"}, 1, 0);
    else chk(tag, wq.pop_front(), exp);
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    chk_reset_vals("rst");
    RESET_X = 1'b0; tick();

    // LEN=8, bytes 01..08 back-to-back
    done_cnt = 0; wq.delete();
    start(16'd8);
    chk("t8_busy", BUSY, 1);
    chk("t8_in_ready", IN_READY, 1);
    for (int i = 0; i < 8; i++) begin
      send(8'(i + 1), 16'h0, 16'h0);
      if (i == 3) chk("t8_first_word_lat", {WR_VALID, WR_DATA}, {1'b1, 32'h04030201});
    end
    wait_done(20, ok); chk("t8_done_seen", ok, 1);
    tick();
    chk("t8_done_once", done_cnt, 1);
    chk("t8_idle", BUSY, 0);
    chk("t8_nwords", wq.size(), 2);
    chk_word("t8_w0", {1'b0, 32'h04030201});
    chk_word("t8_w1", {1'b1, 32'h08070605});
    chk("t8_cmin_cmax", {C_MIN, C_MAX}, 16'h0108);

    // LEN=5, partial last word
    done_cnt = 0; wq.delete();
    start(16'd5);
    for (int i = 0; i < 5; i++) send(8'((i + 1) * 16), 16'h1000 + 16'(i), 16'h2000 + 16'(i));
    chk("t5_flush_no_valid", WR_VALID, 0);
    tick();
    chk("t5_partial_out", {WR_VALID, WR_LAST, WR_DATA}, {2'b11, 32'h00000050});
    wait_done(20, ok); chk("t5_done_seen", ok, 1);
    tick();
    chk("t5_nwords", wq.size(), 2);
    chk_word("t5_w0", {1'b0, 32'h40302010});
    chk_word("t5_w1", {1'b1, 32'h00000050});
    chk("t5_range", {RANGE_MIN, RANGE_MAX}, {16'h1004, 16'h2004});
    chk("t5_cmin_cmax", {C_MIN, C_MAX}, 16'h1050);

    // LEN=0
    done_cnt = 0; wq.delete();
    start(16'd0);
    chk("t0_done_busy_valid", {DONE, BUSY, WR_VALID}, 3'b110);
    tick();
    chk("t0_after", {DONE, BUSY, WR_VALID}, 3'b000);
    chk("t0_nwords", wq.size(), 0);

    // LEN=24 with sink stalled: overflow
    done_cnt = 0; wq.delete();
    WR_READY = 1'b0;
    start(16'd24);
    for (int i = 0; i < 24; i++) begin
      send(8'(i + 1), 16'h0, 16'h0);
      if (i == 7)  chk("t24_ready_2words", IN_READY, 1);
      if (i == 11) chk("t24_ready_3words", IN_READY, 0);
    end
    chk("t24_stall_data", {WR_VALID, WR_LAST, WR_DATA}, {2'b10, 32'h04030201});
    chk("t24_ovf", OVF, 1);
    chk("t24_busy_drain", {BUSY, DONE}, 2'b10);
    WR_READY = 1'b1;
    wait_done(20, ok); chk("t24_done_seen", ok, 1);
    tick();
    chk("t24_done_once", done_cnt, 1);
    chk("t24_nwords", wq.size(), 4);
    chk_word("t24_w0", {1'b0, 32'h04030201});
    chk_word("t24_w1", {1'b0, 32'h08070605});
    chk_word("t24_w2", {1'b0, 32'h0C0B0A09});
    chk_word("t24_w3", {1'b0, 32'h100F0E0D});

    // reset mid-frame, then a clean LEN=4 frame
    start(16'd8);
    for (int i = 0; i < 5; i++) send(8'(i + 1), 16'h0, 16'h0);
    RESET_X = 1'b1; INPUT_EN = 1'b1; C_IN = 8'h06;
    tick();
    RESET_X = 1'b0; INPUT_EN = 1'b0;
    chk_reset_vals("mid");
    done_cnt = 0; wq.delete();
    start(16'd4);
    for (int i = 0; i < 4; i++) send(8'hA1 + 8'(i), 16'h0, 16'h0);
    wait_done(20, ok); chk("r4_done_seen", ok, 1);
    tick();
    chk("r4_nwords", wq.size(), 1);
    chk_word("r4_w0", {1'b1, 32'hA4A3A2A1});

    // INPUT_EN in IDLE ignored
    send(8'h00, 16'h0, 16'h0);
    chk("idle_in_ignored", {BUSY, WR_VALID, C_MIN, C_MAX}, {2'b00, 16'hA1A4});

    // START during RUN ignored
    done_cnt = 0; wq.delete();
    start(16'd8);
    send(8'h01, 16'h0, 16'h0);
    send(8'h02, 16'h0, 16'h0);
    start(16'd1);
    chk("run_start_ignored", {BUSY, OVF, C_MIN, C_MAX}, {2'b10, 16'h0102});
    for (int i = 2; i < 8; i++) send(8'(i + 1), 16'h0, 16'h0);
    wait_done(20, ok); chk("rs_done_seen", ok, 1);
    tick();
    chk("rs_done_once", done_cnt, 1);
    chk("rs_nwords", wq.size(), 2);
    chk_word("rs_w0", {1'b0, 32'h04030201});
    chk_word("rs_w1", {1'b1, 32'h08070605});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
